// File: rtl/fp_divide.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_divide : sequential IEEE-754 single-precision divider, result truncated  |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fp_divide #(
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        div_start,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] div_result,
  output logic        div_overflow,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_NORM = 2'd2
  } state_t;

  localparam logic [4:0] c_last_iter = 5'(QBITS - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_s1;
  logic        r_s2;
  logic [7:0]  r_e1;
  logic [7:0]  r_e2;
  logic [23:0] r_m2;
  logic [25:0] r_rem;
  logic [QBITS-1:0] r_q;
  logic [4:0]  r_cnt;

  logic               w_sign;
  logic signed [9:0]  w_exp;
  logic [22:0]        w_frac;
  logic [31:0]        w_result;
  logic               w_ovf;
  logic               w_dbz;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (div_start) w_next = S_CALC;
      S_CALC:  if (r_cnt == c_last_iter) w_next = S_NORM;
      S_NORM:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Special cases take priority over the normalised quotient, divide-by-zero first.
  always_comb begin
    w_sign = r_s1 ^ r_s2;
    w_exp  = $signed({2'b00, r_e1}) - $signed({2'b00, r_e2})
           + (r_q[QBITS-1] ? 10'sd127 : 10'sd126);
    w_frac = r_q[QBITS-1] ? r_q[QBITS-2:1] : r_q[QBITS-3:0];
    w_ovf  = 1'b0;
    w_dbz  = 1'b0;
    if (r_e2 == 8'd0) begin
      w_result = {w_sign, 8'hFF, 23'd0};
      w_dbz    = 1'b1;
    end else if (r_e1 == 8'd0) begin
      w_result = {w_sign, 31'd0};
    end else if (w_exp >= 10'sd255) begin
      w_result = {w_sign, 8'hFF, 23'd0};
      w_ovf    = 1'b1;
    end else if (w_exp <= 10'sd0) begin
      w_result = {w_sign, 31'd0};
    end else begin
      w_result = {w_sign, w_exp[7:0], w_frac};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_e1         <= 8'd0;
      r_e2         <= 8'd0;
      r_m2         <= 24'd0;
      r_rem        <= 26'd0;
      r_q          <= '0;
      r_cnt        <= 5'd0;
      div_busy     <= 1'b0;
      div_done     <= 1'b0;
      div_result   <= 32'd0;
      div_overflow <= 1'b0;
      div_by_zero  <= 1'b0;
    end else begin
      div_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (div_start) begin
            r_s1     <= op1[31];
            r_s2     <= op2[31];
            r_e1     <= op1[30:23];
            r_e2     <= op2[30:23];
            r_m2     <= {op2[30:23] != 8'd0, op2[22:0]};
            r_rem    <= {2'b00, op1[30:23] != 8'd0, op1[22:0]};
            r_q      <= '0;
            r_cnt    <= 5'd0;
            div_busy <= 1'b1;
          end
        end
        S_CALC: begin
          if (r_rem >= {2'b00, r_m2}) begin
            r_q   <= {r_q[QBITS-2:0], 1'b1};
            r_rem <= (r_rem - {2'b00, r_m2}) << 1;
          end else begin
            r_q   <= {r_q[QBITS-2:0], 1'b0};
            r_rem <= r_rem << 1;
          end
          r_cnt <= r_cnt + 5'd1;
        end
        S_NORM: begin
          div_result   <= w_result;
          div_overflow <= w_ovf;
          div_by_zero  <= w_dbz;
          div_done     <= 1'b1;
          div_busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_divide.sv
`default_nettype none
// Self-checking bench for fp_divide: directed plan cases plus random operands
// checked against an arithmetic reference model.
module tb_fp_divide;

  logic        clk;
  logic        n_rst;
  logic        div_start;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_result;
  logic        div_overflow;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  fp_divide dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .div_start    (div_start),
    .op1          (op1),
    .op2          (op2),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .div_result   (div_result),
    .div_overflow (div_overflow),
    .div_by_zero  (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, div_by_zero, result}; quotient of true mantissas, truncated.
  function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    longint      m1, m2, q;
    logic [22:0] frac;
    s = a[31] ^ b[31];
    if (b[30:23] == 8'd0) return {2'b01, s, 8'hFF, 23'd0};
    if (a[30:23] == 8'd0) return {2'b00, s, 31'd0};
    m1 = longint'({1'b1, a[22:0]});
    m2 = longint'({1'b1, b[22:0]});
    q  = (m1 << 24) / m2;
    if (q >= (64'sd1 <<< 24)) begin
      e    = int'(a[30:23]) - int'(b[30:23]) + 127;
      frac = q[23:1];
    end else begin
      e    = int'(a[30:23]) - int'(b[30:23]) + 126;
      frac = q[22:0];
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b00, s, 31'd0};
    return {2'b00, s, 8'(e), frac};
  endfunction

  // Leaves time at 1 unit after the sampling edge; operands are scrambled afterwards.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    op1       = a;
    op2       = b;
    div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    op1       = $urandom;
    op2       = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    lat    = -1;
    busy_n = 0;
    for (int k = 1; k <= 40; k++) begin
      if (div_busy) busy_n++;
      @(posedge clk); #1;
      if (div_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input logic [1:0] exp_flags);
    int lat, busy_n;
    start_op(a, b);
    wait_done(lat, busy_n);
    chk({tag, "_latency"}, lat, 26);
    chk({tag, "_result"}, div_result, exp_res);
    chk({tag, "_flags"}, {30'd0, div_overflow, div_by_zero}, {30'd0, exp_flags});
  endtask

  initial begin
    int          lat, busy_n;
    logic [33:0] r;
    logic [31:0] a, b;

    n_rst     = 1'b0;
    div_start = 1'b0;
    op1       = 32'd0;
    op2       = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", div_result, 32'd0);
    chk("reset_ctrl", {28'd0, div_busy, div_done, div_overflow, div_by_zero}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // 3.75 / 1.5 with latency, busy-length and pulse-width checks
    start_op(32'h40700000, 32'h3FC00000);
    wait_done(lat, busy_n);
    chk("basic_latency", lat, 26);
    chk("basic_busy_cycles", busy_n, 26);
    chk("basic_result", div_result, 32'h40200000);
    chk("basic_flags", {30'd0, div_overflow, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    chk("basic_done_pulse", {31'd0, div_done}, 32'd0);
    chk("basic_hold", div_result, 32'h40200000);

    run("neg6_div", 32'hC0C00000, 32'h3FC00000, 32'hC0800000, 2'b00);
    run("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 2'b00);
    run("div_zero", 32'h40000000, 32'h00000000, 32'h7F800000, 2'b01);
    run("neg_zero_num", 32'h80000000, 32'h40000000, 32'h80000000, 2'b00);
    run("zero_zero", 32'h00000000, 32'h00000000, 32'h7F800000, 2'b01);
    run("overflow", 32'h7F000000, 32'h3F000000, 32'h7F800000, 2'b10);
    run("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 2'b00);

    // Start pulse during CALC is ignored
    start_op(32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    #1;
    op1       = 32'h41200000;
    op2       = 32'h3F800000;
    div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    wait_done(lat, busy_n);
    chk("ignore_latency", lat, 16);
    chk("ignore_result", div_result, 32'h40400000);

    // Start while div_done is high is accepted immediately
    run("back_to_back", 32'h41200000, 32'h40A00000, 32'h40000000, 2'b00);

    // Asynchronous reset between edges mid-CALC
    start_op(32'h40C00000, 32'h40000000);
    repeat (12) @(posedge clk);
    #4;
    n_rst = 1'b0;
    #1;
    chk("abort_result", div_result, 32'd0);
    chk("abort_ctrl", {28'd0, div_busy, div_done, div_overflow, div_by_zero}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    lat = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (div_done) lat++;
    end
    chk("abort_no_done", lat, 0);
    run("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 2'b00);

    // Random operands against the reference model
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 8 == 3) a[30:23] = 8'd0;
      if (i % 8 == 5) b[30:23] = 8'd0;
      if (i % 2 == 0) begin
        a[30:23] = 8'($urandom_range(100, 154));
        b[30:23] = 8'($urandom_range(100, 154));
      end
      r = ref_div(a, b);
      run($sformatf("rand%0d", i), a, b, r[31:0], r[33:32]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
